// File: rtl/pwm_ramp_ctrl.sv
// Duty ramp sequencer for a PWM core; start->initial_update 1 cycle, ->pwm_en 2 cycles, ticks every cfg_interval+1.
// No backpressure: start/stop are single-cycle requests, stop beats start, start ignored while stopping.
module pwm_ramp_ctrl (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [9:0]  cfg_period,
    input  logic [9:0]  cfg_target,
    input  logic [9:0]  cfg_step,
    input  logic [15:0] cfg_interval,
    output logic        pwm_en,
    output logic [9:0]  initial_cycle,
    output logic [9:0]  initial_duty_cycle,
    output logic        initial_update,
    output logic [9:0]  duty_cycle,
    output logic        duty_cycle_update,
    output logic        up,
    output logic        down,
    output logic        busy,
    output logic        at_target
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RAMP_UP = 3'd2,
        RAMP_DN = 3'd3,
        HOLD    = 3'd4,
        OFF     = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  period_q, period_d;
    logic [9:0]  target_q, target_d;
    logic [9:0]  step_q, step_d;
    logic [9:0]  cur_q, cur_d;
    logic [15:0] cnt_q, cnt_d;
    logic        stopping_q, stopping_d;

    logic [9:0]  clamp_period;
    logic [9:0]  new_target;
    logic [9:0]  new_step;
    logic [9:0]  floor_val;
    logic [10:0] up_sum;
    logic [9:0]  up_val;
    logic [9:0]  dn_diff;
    logic [9:0]  dn_val;
    logic [9:0]  tick_val;
    logic        ramping;
    logic        tick;

    always_comb begin
        clamp_period = (state_q == IDLE) ? cfg_period : period_q;
        new_target   = (cfg_target > clamp_period) ? clamp_period : cfg_target;
        new_step     = (cfg_step == 10'd0) ? 10'd1 : cfg_step;
        floor_val    = stopping_q ? 10'd0 : target_q;
        up_sum       = {1'b0, cur_q} + {1'b0, step_q};
        up_val       = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[9:0];
        dn_diff      = cur_q - step_q;
        // The wrapped difference is discarded whenever cur < step.
        dn_val       = ((cur_q < step_q) || (dn_diff < floor_val)) ? floor_val : dn_diff;
        ramping      = (state_q == RAMP_UP) || (state_q == RAMP_DN);
        tick         = ramping && (cnt_q == cfg_interval);
        tick_val     = (state_q == RAMP_UP) ? up_val : dn_val;
    end

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        target_d   = target_q;
        step_d     = step_q;
        cur_d      = cur_q;
        cnt_d      = 16'd0;
        stopping_d = stopping_q;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    period_d = cfg_period;
                    target_d = new_target;
                    step_d   = new_step;
                    cur_d    = 10'd0;
                    state_d  = INIT;
                end
            end
            INIT: begin
                if (stop)
                    state_d = OFF;
                else if (target_q == 10'd0)
                    state_d = HOLD;
                else
                    state_d = RAMP_UP;
            end
            RAMP_UP, RAMP_DN, HOLD: begin
                if (tick) begin
                    cur_d = tick_val;
                    if (tick_val == floor_val)
                        state_d = stopping_q ? OFF : HOLD;
                end else if (ramping) begin
                    cnt_d = cnt_q + 16'd1;
                end
                // Requests act on the post-tick duty so a same-cycle tick is never lost.
                if (stop && !stopping_q) begin
                    stopping_d = 1'b1;
                    cnt_d      = 16'd0;
                    state_d    = (cur_d == 10'd0) ? OFF : RAMP_DN;
                end else if (start && !stop && !stopping_q) begin
                    target_d = new_target;
                    step_d   = new_step;
                    cnt_d    = 16'd0;
                    if (new_target > cur_d)
                        state_d = RAMP_UP;
                    else if (new_target < cur_d)
                        state_d = RAMP_DN;
                    else
                        state_d = HOLD;
                end
            end
            OFF: begin
                stopping_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= IDLE;
            period_q   <= 10'd0;
            target_q   <= 10'd0;
            step_q     <= 10'd0;
            cur_q      <= 10'd0;
            cnt_q      <= 16'd0;
            stopping_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            target_q   <= target_d;
            step_q     <= step_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            stopping_q <= stopping_d;
        end
    end

    // Outputs are masked while rst is high so the reset values appear immediately.
    always_comb begin
        pwm_en             = !rst && ((state_q == RAMP_UP) || (state_q == RAMP_DN) || (state_q == HOLD));
        initial_update     = !rst && (state_q == INIT);
        initial_cycle      = rst ? 10'd0 : period_q;
        initial_duty_cycle = 10'd0;
        duty_cycle_update  = !rst && tick;
        duty_cycle         = rst ? 10'd0 : (tick ? tick_val : cur_q);
        up                 = 1'b0;
        down               = 1'b0;
        busy               = !rst && (state_q != IDLE);
        at_target          = !rst && (state_q == HOLD);
    end

endmodule
